// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit for the Execute stage.
// Works on operand magnitudes, one radix-2 step per cycle for WIDTH cycles,
// and applies the result sign when the result is presented in DONE.
module muldiv_unit #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             StartE,
   input  logic [2:0]       FunctE,
   input  logic [WIDTH-1:0] SrcAE,
   input  logic [WIDTH-1:0] SrcBE,
   output logic             BusyE,
   output logic             DoneE,
   output logic [WIDTH-1:0] ResultE
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_t;

   state_t             state_q, state_d;
   logic [2:0]         funct_q, funct_d;
   logic [WIDTH-1:0]   mag_b_q, mag_b_d;
   logic               neg_q, neg_d;
   logic [CW-1:0]      count_q, count_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;

   logic               a_signed, b_signed;
   logic               a_neg, b_neg, b_zero;
   logic [WIDTH-1:0]   mag_a;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_rem_sh;
   logic [WIDTH:0]     div_diff;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   div_sel;
   logic [WIDTH-1:0]   div_fix;
   logic [WIDTH-1:0]   result;

   // State, latched operands, counter and accumulator registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         funct_q <= '0;
         mag_b_q <= '0;
         neg_q   <= 1'b0;
         count_q <= '0;
         acc_q   <= '0;
      end else begin
         state_q <= state_d;
         funct_q <= funct_d;
         mag_b_q <= mag_b_d;
         neg_q   <= neg_d;
         count_q <= count_d;
         acc_q   <= acc_d;
      end
   end

   // Next-state logic: accept in IDLE, WIDTH steps in CALC, one DONE cycle
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (StartE) state_d = CALC;
         CALC:    if (count_q == CW'(WIDTH - 1)) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Operand decode, accept-time latching and one multiply/divide step per CALC cycle
   always_comb begin
      // MUL/MULH: both signed; MULHSU: rs1 signed; MULHU: neither; DIV/REM: both signed
      a_signed = FunctE[2] ? ~FunctE[0] : (FunctE[1:0] != 2'b11);
      b_signed = FunctE[2] ? ~FunctE[0] : ~FunctE[1];
      a_neg    = a_signed & SrcAE[WIDTH-1];
      b_neg    = b_signed & SrcBE[WIDTH-1];
      b_zero   = (SrcBE == '0);
      mag_a    = a_neg ? -SrcAE : SrcAE;

      mul_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mag_b_q} : '0);
      div_rem_sh = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      div_diff   = div_rem_sh - {1'b0, mag_b_q};

      funct_d = funct_q;
      mag_b_d = mag_b_q;
      neg_d   = neg_q;
      count_d = count_q;
      acc_d   = acc_q;

      case (state_q)
         IDLE: begin
            if (StartE) begin
               funct_d = FunctE;
               mag_b_d = b_neg ? -SrcBE : SrcBE;
               // A zero divisor leaves an all-ones positive quotient, which is the
               // required DIV/DIVU result; the remainder keeps the dividend sign.
               if (FunctE[2])
                  neg_d = FunctE[1] ? a_neg : ((a_neg ^ b_neg) & ~b_zero);
               else
                  neg_d = a_neg ^ b_neg;
               count_d = '0;
               acc_d   = {{WIDTH{1'b0}}, mag_a};
            end
         end
         CALC: begin
            count_d = count_q + CW'(1);
            if (funct_q[2]) begin
               if (!div_diff[WIDTH])
                  acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
               else
                  acc_d = {div_rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            end else begin
               acc_d = {mul_sum, acc_q[WIDTH-1:1]};
            end
         end
         default: ;
      endcase
   end

   // Outputs: stall request, done strobe and sign-corrected result
   always_comb begin
      prod_fix = neg_q ? -acc_q : acc_q;
      div_sel  = funct_q[1] ? acc_q[2*WIDTH-1:WIDTH] : acc_q[WIDTH-1:0];
      div_fix  = neg_q ? -div_sel : div_sel;
      if (funct_q[2])
         result = div_fix;
      else if (funct_q[1:0] == 2'b00)
         result = prod_fix[WIDTH-1:0];
      else
         result = prod_fix[2*WIDTH-1:WIDTH];

      BusyE   = ((state_q == IDLE) && StartE) || (state_q == CALC);
      DoneE   = (state_q == DONE);
      ResultE = DoneE ? result : '0;
   end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, operand/result width; only 32 is required for RV32M.
REQ-002 The module SHALL have one clock and a synchronous, active-high reset, with the ports below (clock and reset first):
- clk  input  1  rising-edge clock
- reset  input  1  synchronous active-high reset
- StartE  input  1  M-extension instruction valid in Execute
- FunctE  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- SrcAE  input  WIDTH  rs1 operand, already forwarded
- SrcBE  input  WIDTH  rs2 operand, already forwarded
- BusyE  output  1  structural stall request to the hazard unit
- DoneE  output  1  ResultE valid this cycle
- ResultE  output  WIDTH  M-extension result, muxed into ALUResultE

Function
REQ-003 The module SHALL contain a state machine with states IDLE, CALC and DONE.
REQ-004 In IDLE with StartE=1, the module SHALL:
- assert BusyE combinationally in that same cycle;
- latch FunctE, the operand magnitudes and the result sign;
- clear the iteration counter;
- go to CALC at the next edge.
REQ-005 In IDLE with StartE=0, BusyE and DoneE SHALL be 0 and the state SHALL remain IDLE.
REQ-006 CALC SHALL perform one shift-add (multiply) or one restoring-subtract (divide) step per cycle, for exactly WIDTH cycles.
REQ-007 In CALC, BusyE SHALL be 1. After the step with counter = WIDTH-1, the state SHALL go to DONE.
REQ-008 In DONE, the module SHALL:
- drive BusyE=0 and DoneE=1;
- present ResultE;
- ignore StartE, because the same instruction is still in Execute;
- return to IDLE unconditionally at the next edge.
REQ-009 Total Execute occupancy SHALL be WIDTH+2 cycles (34 for RV32): 1 accept cycle, 32 CALC cycles and 1 DONE cycle. BusyE SHALL be high for exactly the first 33 of those cycles.
REQ-010 ResultE SHALL be 0 whenever DoneE=0.
REQ-011 The operation results SHALL be:
- MUL: low WIDTH bits of the product.
- MULH: high WIDTH bits of signed×signed.
- MULHSU: high WIDTH bits of signed(rs1)×unsigned(rs2).
- MULHU: high WIDTH bits of unsigned×unsigned.
REQ-012 Signed division SHALL truncate toward zero. The remainder sign SHALL equal the dividend sign.
REQ-013 For divide by zero (SrcBE=0):
- DIV and DIVU: ResultE SHALL be all ones.
- REM and REMU: ResultE SHALL be SrcAE.
These results SHALL still take full latency.
REQ-014 For signed overflow (SrcAE=0x80000000, SrcBE=0xFFFFFFFF):
- DIV: ResultE SHALL be 0x80000000.
- REM: ResultE SHALL be 0.
These results SHALL still take full latency.
REQ-015 Sign fix-up (negation of the magnitude result) SHALL be applied when producing ResultE in DONE. The 2WIDTH-bit product SHALL be negated as a whole before high/low selection.
REQ-016 Operand and FunctE changes after the accept cycle SHALL NOT affect the result. The pipeline holds them via StallE, but the latched copies SHALL be used.
REQ-017 StartE deasserting during CALC (for example, reset of the upstream pipeline is not expected) SHALL NOT abort the operation; only reset aborts.
REQ-018 Back-to-back M instructions SHALL work as follows:
- The second instruction enters Execute on the edge ending DONE.
- It is accepted in the following IDLE cycle, with no lost or merged operation.

Reset
REQ-019 Reset SHALL force state IDLE and clear the counter, latched operands and accumulator.
REQ-020 During reset and in the cycle after it, BusyE, DoneE and ResultE SHALL be 0, provided StartE=0.
REQ-021 Reset asserted during CALC or DONE SHALL abort the operation at that edge, with no DoneE pulse produced.
REQ-022 Reset SHALL take priority over StartE in the same cycle.

Verification
REQ-023 MUL check: StartE=1, FunctE=000, SrcAE=7, SrcBE=0xFFFFFFFA (−6).
- BusyE SHALL be high for 33 cycles.
- DoneE SHALL rise in cycle 34 with ResultE=0xFFFFFFD6 (−42).
REQ-024 MULH and MULHU check: SrcAE=SrcBE=0x80000000.
- MULH SHALL give ResultE=0x40000000.
- MULHU SHALL give ResultE=0x40000000.
- MULHSU with SrcAE=0xFFFFFFFF, SrcBE=0xFFFFFFFF SHALL give ResultE=0xFFFFFFFF.
REQ-025 Division check: DIV with SrcAE=−7, SrcBE=2 SHALL give 0xFFFFFFFD (−3); REM with the same operands SHALL give 0xFFFFFFFF (−1).
REQ-026 Corner cases:
- DIVU 5/0 SHALL give 0xFFFFFFFF.
- REMU 5/0 SHALL give 5.
- DIV 0x80000000/−1 SHALL give 0x80000000.
- REM with the same operands SHALL give 0.
All of these SHALL take the full 34 cycles.
REQ-027 Reset abort: reset pulsed at CALC cycle 10 -> next cycle BusyE=0 and DoneE=0; a new DIVU 100/7 then SHALL yield 14 after 34 cycles.
REQ-028 Back-to-back: MUL 3×4 then DIVU 100/7 with StartE held high -> DoneE SHALL pulse with 12, then pulse 34 cycles later with 14, and BusyE SHALL be low only in each DONE cycle.
